// File: rtl/regression_sample_loader.sv
// regression_sample_loader
//   Write-side front end for the linear-regression engine. Accepts (x, y)
//   sample pairs over a valid/ready handshake, writes them to the engine's
//   sample memory at consecutive addresses from 0, then pulses eng_start with
//   the batch length and holds off input until the engine reports eng_done.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready sample handshake (in_ready is combinational from state)
//   in_x, in_y        sample pair
//   in_last           final sample of a batch, qualified by the handshake
//   mem_we/addr/wx/wy registered sample memory write port
//   eng_start         one-cycle start pulse to the engine
//   n_samples         length of the most recently closed batch
//   eng_done          engine finished (level or pulse), honoured only in RUN
//   trunc             sticky: last batch closed at N_SAMPLES without in_last
//   batch_cnt         completed batches, wraps modulo 2^16
module regression_sample_loader #(
   parameter int unsigned DATA_W    = 20,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned N_SAMPLES = 150
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_x,
   input  logic [DATA_W-1:0] in_y,
   input  logic              in_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wx,
   output logic [DATA_W-1:0] mem_wy,
   output logic              eng_start,
   output logic [ADDR_W:0]   n_samples,
   input  logic              eng_done,
   output logic              trunc,
   output logic [15:0]       batch_cnt
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

   typedef enum logic [1:0] {LOAD, FLUSH, LAUNCH, RUN} state_t;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] wr_ptr;
   logic              accept;
   logic              close;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LOAD;
      else     state <= state_next;
   end

   // Next-state and handshake decode
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      accept     = 1'b0;
      close      = 1'b0;
      case (state)
         LOAD: begin
            in_ready = 1'b1;
            accept   = in_valid;
            // batch closes on in_last or when the last address is written
            close    = in_valid & (in_last | (wr_ptr == LAST_ADDR));
            if (close) state_next = FLUSH;
         end
         FLUSH:   state_next = LAUNCH;
         LAUNCH:  state_next = RUN;
         RUN:     if (eng_done) state_next = LOAD;
         default: state_next = LOAD;
      endcase
   end

   // Write port, batch bookkeeping and engine start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wx    <= '0;
         mem_wy    <= '0;
         eng_start <= 1'b0;
         n_samples <= '0;
         trunc     <= 1'b0;
         batch_cnt <= '0;
      end else begin
         mem_we <= accept;
         // registered one cycle after FLUSH so it lands in LAUNCH, after the final write
         eng_start <= (state == FLUSH);
         if (accept) begin
            mem_addr <= wr_ptr;
            mem_wx   <= in_x;
            mem_wy   <= in_y;
            wr_ptr   <= wr_ptr + ADDR_W'(1);
            if (wr_ptr == '0) trunc <= 1'b0;
         end
         if (close) begin
            n_samples <= {1'b0, wr_ptr} + (ADDR_W + 1)'(1);
            if (!in_last) trunc <= 1'b1;
         end
         if ((state == RUN) && eng_done) begin
            wr_ptr    <= '0;
            batch_cnt <= batch_cnt + 16'd1;
         end
      end
   end

endmodule
